// File: rtl/interrupt_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, IME sequencing and fixed-priority dispatch.
// Optional INTC_WAKE_EN builds the HALT wake output (|pending); otherwise wake is tied low.
module interrupt_ctrl #(
  parameter logic [15:0] IF_ADDR     = 16'hff0f,
  parameter logic [15:0] IE_ADDR     = 16'hffff,
  parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
  input  logic        clockgb,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  input  logic [4:0]  irq_src,
  input  logic        ime_set,
  input  logic        ime_set_now,
  input  logic        ime_clear,
  input  logic        instr_done,
  output logic        int_req,
  output logic [15:0] int_vector,
  input  logic        int_ack,
  output logic        wake
);

  localparam int unsigned N_SRC = 5;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {IME_OFF, IME_ARMED, IME_ON} ime_e;
  typedef enum logic {ST_IDLE, ST_PENDING} disp_e;

  logic [N_SRC-1:0] if_q, if_d;
  logic [7:0]       ie_q, ie_d;
  ime_e             ime_q, ime_d;
  disp_e            state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             int_req_q, int_req_d;
  logic [15:0]      int_vector_q, int_vector_d;

  logic [N_SRC-1:0] pend;
  logic [IDX_W-1:0] first_idx;
  logic             ack_fire;

  assign pend     = if_q & ie_q[N_SRC-1:0];
  assign ack_fire = (state_q == ST_PENDING) && int_ack;

  // Lowest set bit of pend wins (vblank highest priority)
  always_comb begin
    first_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pend[i]) first_idx = IDX_W'(i);
    end
  end

  always_comb begin
    if_d         = if_q;
    ie_d         = ie_q;
    ime_d        = ime_q;
    state_d      = state_q;
    idx_d        = idx_q;
    int_vector_d = int_vector_q;

    // IF update order gives irq_src > store > ack clear
    if (ack_fire) if_d[idx_q] = 1'b0;
    if (store && (address == IF_ADDR)) if_d = indata[N_SRC-1:0];
    if_d = if_d | irq_src;

    if (store && (address == IE_ADDR)) ie_d = indata;

    if (ime_clear) begin
      ime_d = IME_OFF;
    end else if (ack_fire) begin
      ime_d = IME_OFF;
    end else if (ime_set_now) begin
      ime_d = IME_ON;
    end else if (ime_q == IME_OFF && ime_set) begin
      ime_d = IME_ARMED;
    end else if (ime_q == IME_ARMED && instr_done) begin
      ime_d = IME_ON;
    end

    case (state_q)
      ST_IDLE: begin
        if (ime_q == IME_ON && pend != '0) begin
          state_d      = ST_PENDING;
          idx_d        = first_idx;
          int_vector_d = VECTOR_BASE + 16'({first_idx, 3'b000});
        end
      end
      ST_PENDING: begin
        if (int_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    int_req_d = (state_d == ST_PENDING);
  end

  always_ff @(posedge clockgb) begin
    if (reset) begin
      if_q         <= '0;
      ie_q         <= '0;
      ime_q        <= IME_OFF;
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      int_req_q    <= 1'b0;
      int_vector_q <= '0;
    end else begin
      if_q         <= if_d;
      ie_q         <= ie_d;
      ime_q        <= ime_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      int_req_q    <= int_req_d;
      int_vector_q <= int_vector_d;
    end
  end

  assign int_req    = int_req_q;
  assign int_vector = int_vector_q;

  // Bus read mux; zero when not addressed so it can be ORed onto the bus
  always_comb begin
    outdata = 8'h00;
    if (load && address == IF_ADDR)      outdata = {3'b111, if_q};
    else if (load && address == IE_ADDR) outdata = ie_q;
  end

`ifdef INTC_WAKE_EN
  assign wake = |pend;
`else
  assign wake = 1'b0;
`endif

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: vector table for dispatch/IME/IF races plus bus, reset and wake sequences.
module tb_interrupt_ctrl;

  localparam logic [15:0] IF_A = 16'hff0f;
  localparam logic [15:0] IE_A = 16'hffff;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  indata;
  logic [7:0]  outdata;
  logic        load, store;
  logic [4:0]  irq_src;
  logic        ime_set, ime_set_now, ime_clear, instr_done;
  logic        int_req;
  logic [15:0] int_vector;
  logic        int_ack;
  logic        wake;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  interrupt_ctrl dut (
    .clockgb(clk), .reset(reset), .address(address), .indata(indata), .outdata(outdata),
    .load(load), .store(store), .irq_src(irq_src), .ime_set(ime_set),
    .ime_set_now(ime_set_now), .ime_clear(ime_clear), .instr_done(instr_done),
    .int_req(int_req), .int_vector(int_vector), .int_ack(int_ack), .wake(wake)
  );

  typedef struct {
    logic [1:0]  wr;      // 0 none, 1 IF store, 2 IE store
    logic [7:0]  data;
    logic [4:0]  irq;
    logic        now, set, clr, done, ack;
    logic [7:0]  exp_if;
    logic        exp_req;
    logic [15:0] exp_vec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] wr, input logic [7:0] data, input logic [4:0] irq,
                     input logic now, input logic set, input logic clr, input logic done,
                     input logic ack, input logic [7:0] exp_if, input logic exp_req,
                     input logic [15:0] exp_vec);
    vec_t v;
    v.wr = wr; v.data = data; v.irq = irq; v.now = now; v.set = set; v.clr = clr;
    v.done = done; v.ack = ack; v.exp_if = exp_if; v.exp_req = exp_req; v.exp_vec = exp_vec;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    store = 1'b0; load = 1'b0; address = 16'h0000; indata = 8'h00; irq_src = '0;
    ime_set = 1'b0; ime_set_now = 1'b0; ime_clear = 1'b0; instr_done = 1'b0; int_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [15:0] a);
    load = 1'b1; address = a;
    #1;
  endtask

  task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
    idle_inputs();
    store = 1'b1; address = a; indata = d;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("rst_int_req", 16'(int_req), 16'h0);
    check("rst_int_vector", int_vector, 16'h0000);
    check("rst_wake", 16'(wake), 16'h0);
    check("rst_outdata", 16'(outdata), 16'h00);
    read_reg(IF_A);
    check("rst_if_read", 16'(outdata), 16'h00e0);
    reset = 1'b0;
    idle_inputs();

    // wr  data   irq     now set clr done ack  exp_if req vec
    add(2, 8'h04, 5'h00, 0, 0, 0, 0, 0, 8'he0, 0, 16'h0);      // 1: IE=04
    add(0, 8'h00, 5'h00, 1, 0, 0, 0, 0, 8'he0, 0, 16'h0);
    add(0, 8'h00, 5'h04, 0, 0, 0, 0, 0, 8'he4, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he4, 1, 16'h0050);
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 1, 8'he0, 0, 16'h0);
    add(0, 8'h00, 5'h04, 0, 0, 0, 0, 0, 8'he4, 0, 16'h0);      // IME now off
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he4, 0, 16'h0);
    add(1, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he0, 0, 16'h0);
    add(2, 8'h1f, 5'h00, 0, 0, 0, 0, 0, 8'he0, 0, 16'h0);      // 2: priority
    add(0, 8'h00, 5'h00, 1, 0, 0, 0, 0, 8'he0, 0, 16'h0);
    add(0, 8'h00, 5'h15, 0, 0, 0, 0, 0, 8'hf5, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'hf5, 1, 16'h0040);
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 1, 8'hf4, 0, 16'h0);
    add(0, 8'h00, 5'h00, 1, 0, 0, 0, 0, 8'hf4, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'hf4, 1, 16'h0050);
    add(1, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he0, 1, 16'h0050);   // IF write keeps latched vector
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 1, 8'he0, 0, 16'h0);
    add(1, 8'h01, 5'h00, 0, 0, 0, 0, 0, 8'he1, 0, 16'h0);      // 3: EI delay
    add(0, 8'h00, 5'h00, 0, 1, 0, 0, 0, 8'he1, 0, 16'h0);
    for (int i = 0; i < 5; i++) add(0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he1, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 0, 0, 1, 0, 8'he1, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he1, 1, 16'h0040);
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 1, 8'he0, 0, 16'h0);
    add(1, 8'h01, 5'h00, 0, 0, 0, 0, 0, 8'he1, 0, 16'h0);      // DI cancels ARMED
    add(0, 8'h00, 5'h00, 0, 1, 0, 0, 0, 8'he1, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 0, 1, 0, 0, 8'he1, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 0, 0, 1, 0, 8'he1, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he1, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 1, 0, 1, 0, 8'he1, 0, 16'h0);      // same-cycle instr_done ignored
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he1, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 0, 0, 1, 0, 8'he1, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he1, 1, 16'h0040);
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 1, 8'he0, 0, 16'h0);
    add(1, 8'h00, 5'h04, 0, 0, 0, 0, 0, 8'he4, 0, 16'h0);      // 4: irq beats IF store
    add(0, 8'h00, 5'h00, 1, 0, 0, 0, 0, 8'he4, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he4, 1, 16'h0050);
    add(0, 8'h00, 5'h04, 0, 0, 0, 0, 1, 8'he4, 0, 16'h0);      // irq beats ack clear
    add(1, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he0, 0, 16'h0);
    add(1, 8'h04, 5'h00, 1, 0, 0, 0, 0, 8'he4, 0, 16'h0);
    add(0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he4, 1, 16'h0050);
    add(1, 8'h04, 5'h00, 0, 0, 0, 0, 1, 8'he4, 0, 16'h0);      // store beats ack clear
    add(1, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'he0, 0, 16'h0);

    foreach (tbl[k]) begin
      idle_inputs();
      store = (tbl[k].wr != 2'd0);
      address = (tbl[k].wr == 2'd2) ? IE_A : IF_A;
      indata = tbl[k].data; irq_src = tbl[k].irq;
      ime_set_now = tbl[k].now; ime_set = tbl[k].set; ime_clear = tbl[k].clr;
      instr_done = tbl[k].done; int_ack = tbl[k].ack;
      tick();
      idle_inputs();
      read_reg(IF_A);
      check($sformatf("row%0d_if", k), 16'(outdata), 16'(tbl[k].exp_if));
      check($sformatf("row%0d_req", k), 16'(int_req), 16'(tbl[k].exp_req));
      if (tbl[k].exp_req) check($sformatf("row%0d_vec", k), int_vector, tbl[k].exp_vec);
    end

    // 5: bus reads
    idle_inputs();
    write_reg(IE_A, 8'ha5);
    read_reg(IE_A);
    check("ie_read_a5", 16'(outdata), 16'h00a5);
    read_reg(16'hff06);
    check("unmapped_read", 16'(outdata), 16'h0000);
    idle_inputs();
    #1;
    check("no_load_read", 16'(outdata), 16'h0000);

    // reset while PENDING
    store = 1'b1; address = IF_A; indata = 8'h01; ime_set_now = 1'b1;
    tick();
    idle_inputs();
    tick();
    check("pre_rst_req", 16'(int_req), 16'h1);
    check("pre_rst_vec", int_vector, 16'h0040);
    reset = 1'b1;
    tick();
    check("mid_rst_req", 16'(int_req), 16'h0);
    read_reg(IF_A);
    check("mid_rst_if", 16'(outdata), 16'h00e0);
    read_reg(IE_A);
    check("mid_rst_ie", 16'(outdata), 16'h0000);
    reset = 1'b0;
    idle_inputs();
    tick();

    // 6: wake with IME off
    write_reg(IE_A, 8'h10);
    irq_src = 5'h10;
    tick();
    idle_inputs();
    #1;
`ifdef INTC_WAKE_EN
    check("wake_on", 16'(wake), 16'h1);
`else
    check("wake_off", 16'(wake), 16'h0);
`endif
    check("wake_req", 16'(int_req), 16'h0);
    tick();
    check("wake_req2", 16'(int_req), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
